// File: rtl/if_id_skid_pkg.sv
// Shared pipeline-core definitions for the IF/ID boundary and its successors.
// Holds the bubble instruction, default payload widths and the occupancy-state
// enum used by every valid/ready pipeline boundary.
package if_id_skid_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam int          ILEN_DEF  = 32;
  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline payload register (instruction, PC, fault flag).
// Ports:
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_clr                 : synchronous clear to the bubble value (wins over load)
//   i_ld                  : load enable for i_d_* payload
//   i_d_instr/pc/fault    : payload to load
//   o_q_instr/pc/fault    : registered payload; bubble is {NOP, 0, 0}
module pipe_slot #(
  parameter int              XLEN = 32,
  parameter int              ILEN = 32,
  parameter logic [ILEN-1:0] NOP  = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic            i_ld,
  input  logic [ILEN-1:0] i_d_instr,
  input  logic [XLEN-1:0] i_d_pc,
  input  logic            i_d_fault,
  output logic [ILEN-1:0] o_q_instr,
  output logic [XLEN-1:0] o_q_pc,
  output logic            o_q_fault
);

  logic [ILEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_fault;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_instr <= NOP;
      r_pc    <= '0;
      r_fault <= 1'b0;
    end else if (i_ld) begin
      r_instr <= i_d_instr;
      r_pc    <= i_d_pc;
      r_fault <= i_d_fault;
    end
  end

  assign o_q_instr = r_instr;
  assign o_q_pc    = r_pc;
  assign o_q_fault = r_fault;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline boundary with valid/ready handshake.
// Handshake: an entry is accepted at an edge where in_valid & in_ready, and
// delivered at an edge where out_valid & out_ready; flush or reset at that edge
// cancels both and empties the boundary.
// SKID=1: main + skid slot, in_ready registered. SKID=0: single slot,
// in_ready = !out_valid | out_ready.
// Ports:
//   clk, rst_n, flush                    : clock, sync active-low reset, flush
//   in_valid/in_ready/in_instr/pc/fault  : fetch side
//   out_valid/out_ready/out_instr/pc/fault : decode side (bubble when !out_valid)
//   dbg_state                            : occupancy state for observation
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int              XLEN = XLEN_DEF,
  parameter int              ILEN = ILEN_DEF,
  parameter logic [ILEN-1:0] NOP  = ILEN'(NOP_INSTR),
  parameter bit              SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_fault,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault,
  output occ_e            dbg_state
);

  occ_e            r_state;
  occ_e            w_state_nx;
  logic            w_acc;
  logic            w_del;
  logic            w_main_ld;
  logic            w_main_clr;
  logic [ILEN-1:0] w_main_d_instr;
  logic [XLEN-1:0] w_main_d_pc;
  logic            w_main_d_fault;

  assign out_valid = (r_state != OCC_EMPTY);
  assign w_acc     = in_valid & in_ready;
  assign w_del     = out_valid & out_ready;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= OCC_EMPTY;
    else        r_state <= w_state_nx;
  end

  // Main slot drives out_* directly; it is cleared whenever it empties so the
  // outputs always show the bubble while out_valid is low.
  pipe_slot #(.XLEN(XLEN), .ILEN(ILEN), .NOP(NOP)) u_main (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clr     (w_main_clr),
    .i_ld      (w_main_ld),
    .i_d_instr (w_main_d_instr),
    .i_d_pc    (w_main_d_pc),
    .i_d_fault (w_main_d_fault),
    .o_q_instr (out_instr),
    .o_q_pc    (out_pc),
    .o_q_fault (out_fault)
  );

  generate
    if (SKID) begin : g_skid
      logic            r_in_ready;
      logic            w_skid_ld;
      logic            w_skid_clr;
      logic            w_sel_skid;
      logic [ILEN-1:0] w_skid_instr;
      logic [XLEN-1:0] w_skid_pc;
      logic            w_skid_fault;

      always_comb begin
        w_state_nx = r_state;
        w_main_ld  = 1'b0;
        w_main_clr = 1'b0;
        w_skid_ld  = 1'b0;
        w_skid_clr = 1'b0;
        w_sel_skid = 1'b0;
        if (flush) begin
          w_state_nx = OCC_EMPTY;
          w_main_clr = 1'b1;
          w_skid_clr = 1'b1;
        end else begin
          case (r_state)
            OCC_EMPTY: begin
              if (w_acc) begin
                w_state_nx = OCC_ONE;
                w_main_ld  = 1'b1;
              end
            end
            OCC_ONE: begin
              if (w_acc && w_del) begin
                w_main_ld = 1'b1;
              end else if (w_acc) begin
                w_state_nx = OCC_FULL;
                w_skid_ld  = 1'b1;
              end else if (w_del) begin
                w_state_nx = OCC_EMPTY;
                w_main_clr = 1'b1;
              end
            end
            OCC_FULL: begin
              // in_ready is low here, so only a deliver can happen.
              if (w_del) begin
                w_state_nx = OCC_ONE;
                w_main_ld  = 1'b1;
                w_sel_skid = 1'b1;
                w_skid_clr = 1'b1;
              end
            end
            default: begin
              w_state_nx = OCC_EMPTY;
              w_main_clr = 1'b1;
              w_skid_clr = 1'b1;
            end
          endcase
        end
      end

      // Registered ready: precomputed from the next state.
      always_ff @(posedge clk) begin
        if (!rst_n) r_in_ready <= 1'b1;
        else        r_in_ready <= (w_state_nx != OCC_FULL);
      end

      assign in_ready       = r_in_ready;
      assign w_main_d_instr = w_sel_skid ? w_skid_instr : in_instr;
      assign w_main_d_pc    = w_sel_skid ? w_skid_pc    : in_pc;
      assign w_main_d_fault = w_sel_skid ? w_skid_fault : in_fault;

      pipe_slot #(.XLEN(XLEN), .ILEN(ILEN), .NOP(NOP)) u_skid (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_clr     (w_skid_clr),
        .i_ld      (w_skid_ld),
        .i_d_instr (in_instr),
        .i_d_pc    (in_pc),
        .i_d_fault (in_fault),
        .o_q_instr (w_skid_instr),
        .o_q_pc    (w_skid_pc),
        .o_q_fault (w_skid_fault)
      );
    end else begin : g_comb
      always_comb begin
        w_state_nx = r_state;
        w_main_ld  = 1'b0;
        w_main_clr = 1'b0;
        if (flush) begin
          w_state_nx = OCC_EMPTY;
          w_main_clr = 1'b1;
        end else begin
          case (r_state)
            OCC_EMPTY: begin
              if (w_acc) begin
                w_state_nx = OCC_ONE;
                w_main_ld  = 1'b1;
              end
            end
            OCC_ONE: begin
              if (w_acc) begin
                w_main_ld = 1'b1;
              end else if (w_del) begin
                w_state_nx = OCC_EMPTY;
                w_main_clr = 1'b1;
              end
            end
            default: begin
              w_state_nx = OCC_EMPTY;
              w_main_clr = 1'b1;
            end
          endcase
        end
      end

      assign in_ready       = !out_valid | out_ready;
      assign w_main_d_instr = in_instr;
      assign w_main_d_pc    = in_pc;
      assign w_main_d_fault = in_fault;
    end
  endgenerate

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: one instance per mode (SKID=1 "skid", SKID=0 "comb")
// sharing the same fetch/decode stimulus.
module tb_if_id_skid;
  import if_id_skid_pkg::*;

  localparam int          W   = 65;  // {fault, pc[31:0], instr[31:0]}
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_fault;
  logic        out_ready;

  logic        s_in_ready, s_out_valid, s_out_fault;
  logic [31:0] s_out_instr, s_out_pc;
  occ_e        s_state;
  logic        c_in_ready, c_out_valid, c_out_fault;
  logic [31:0] c_out_instr, c_out_pc;
  occ_e        c_state;

  logic [W-1:0] exp_q_s[$];
  logic [W-1:0] exp_q_c[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  if_id_skid #(.SKID(1'b1)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_fault(in_fault),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
    .out_pc(s_out_pc), .out_fault(s_out_fault), .dbg_state(s_state)
  );

  if_id_skid #(.SKID(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_fault(in_fault),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_instr(c_out_instr),
    .out_pc(c_out_pc), .out_fault(c_out_fault), .dbg_state(c_state)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Sampled on the falling edge: inputs change just after the rising edge, so
  // everything seen here is what the DUT will act on at the next rising edge.
  task automatic mon_one(input int id, input logic rdy, input logic ov,
                         input logic [31:0] oi, input logic [31:0] op, input logic of);
    logic [W-1:0] got;
    logic [W-1:0] e;
    string pfx;
    pfx = (id == 0) ? "skid" : "comb";
    if (!rst_n || flush) begin
      if (id == 0) exp_q_s.delete(); else exp_q_c.delete();
      return;
    end
    got = {of, op, oi};
    if (!ov) begin
      chk({pfx, "_bubble"}, got, {1'b0, 32'h0, NOP});
    end else if (out_ready) begin
      if ((id == 0 && exp_q_s.size() == 0) || (id == 1 && exp_q_c.size() == 0)) begin
        chk({pfx, "_unexpected_out"}, got, '0);
        if (got == '0) begin
          n_fail++;
          $display("FAIL %s_unexpected_out: delivered %h with empty expected queue", pfx, got);
        end
      end else begin
        e = (id == 0) ? exp_q_s.pop_front() : exp_q_c.pop_front();
        chk({pfx, "_deliver"}, got, e);
      end
    end
    if (in_valid && rdy) begin
      if (id == 0) exp_q_s.push_back({in_fault, in_pc, in_instr});
      else         exp_q_c.push_back({in_fault, in_pc, in_instr});
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, s_in_ready, s_out_valid, s_out_instr, s_out_pc, s_out_fault);
    mon_one(1, c_in_ready, c_out_valid, c_out_instr, c_out_pc, c_out_fault);
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit v, input logic [31:0] pc, input bit f,
                        input bit ordy, input bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = {pc[15:0], pc[15:0]} ^ 32'h0F0F_0013;
    in_fault  = f;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_in(1'b1, 32'hDEAD_BEE0, 1'b1, 1'b1, 1'b0);

    // Reset held two cycles with in_valid high.
    repeat (2) @(posedge clk);
    look();
    chk("rst_s_out_valid", s_out_valid, 0);
    chk("rst_s_out_instr", s_out_instr, NOP);
    chk("rst_s_out_pc",    s_out_pc,    0);
    chk("rst_s_out_fault", s_out_fault, 0);
    chk("rst_s_in_ready",  s_in_ready,  1);
    chk("rst_c_out_valid", c_out_valid, 0);
    chk("rst_c_out_instr", c_out_instr, NOP);
    chk("rst_c_in_ready",  c_in_ready,  1);
    nxt();
    rst_n = 1'b1;

    // Streaming 0x100/0x104/0x108 with out_ready high.
    set_in(1, 32'h100, 0, 1, 0); look();
    chk("str0_s_out_valid", s_out_valid, 0);
    nxt();
    set_in(1, 32'h104, 0, 1, 0); look();
    chk("str1_s_pc", {s_out_valid, s_out_pc}, {1'b1, 32'h100});
    chk("str1_c_pc", {c_out_valid, c_out_pc}, {1'b1, 32'h100});
    nxt();
    set_in(1, 32'h108, 0, 1, 0); look();
    chk("str2_s_pc", {s_out_valid, s_out_pc}, {1'b1, 32'h104});
    chk("str2_c_pc", {c_out_valid, c_out_pc}, {1'b1, 32'h104});
    nxt();
    set_in(0, 32'h0, 0, 1, 0); look();
    chk("str3_s_pc", {s_out_valid, s_out_pc}, {1'b1, 32'h108});
    chk("str3_c_pc", {c_out_valid, c_out_pc}, {1'b1, 32'h108});
    nxt();
    look();
    chk("str4_s_valid", s_out_valid, 0);
    chk("str4_c_valid", c_out_valid, 0);
    nxt();

    // Back-pressure.
    set_in(1, 32'h200, 0, 0, 0); look();
    chk("bp0_s_rdy", s_in_ready, 1);
    nxt();
    set_in(1, 32'h204, 0, 0, 0); look();
    chk("bp1_s_rdy_pc", {s_in_ready, s_out_pc}, {1'b1, 32'h200});
    chk("bp1_c_rdy",    c_in_ready, 0);
    nxt();
    set_in(1, 32'h208, 0, 0, 0); look();
    chk("bp2_s_full",   {s_in_ready, s_out_valid, s_out_pc}, {1'b0, 1'b1, 32'h200});
    chk("bp2_s_state",  s_state, OCC_FULL);
    nxt();
    set_in(1, 32'h208, 0, 1, 0); look();
    chk("bp3_s_rdy_pc", {s_in_ready, s_out_pc}, {1'b0, 32'h200});
    chk("bp3_c_rdy_pc", {c_in_ready, c_out_pc}, {1'b1, 32'h200});
    nxt();
    set_in(1, 32'h208, 0, 1, 0); look();
    chk("bp4_s_rdy_pc", {s_in_ready, s_out_pc}, {1'b1, 32'h204});
    chk("bp4_c_pc",     c_out_pc, 32'h208);
    nxt();
    set_in(0, 32'h0, 0, 1, 0); look();
    chk("bp5_s_pc", {s_out_valid, s_out_pc}, {1'b1, 32'h208});
    nxt();
    look();
    chk("bp6_s_valid", s_out_valid, 0);
    chk("bp6_c_valid", c_out_valid, 0);
    nxt();

    // Flush while FULL with in_valid and out_ready high, then immediate accept.
    set_in(1, 32'h400, 0, 0, 0); nxt();
    set_in(1, 32'h404, 0, 0, 0); nxt();
    set_in(1, 32'h408, 0, 1, 1); look();
    chk("fl0_s_full", s_in_ready, 0);
    nxt();
    set_in(1, 32'h500, 0, 1, 0); look();
    chk("fl1_s_bubble", {s_out_valid, s_out_fault, s_out_pc, s_out_instr}, {2'b00, 32'h0, NOP});
    chk("fl1_s_rdy",    s_in_ready, 1);
    chk("fl1_c_bubble", {c_out_valid, c_out_fault, c_out_pc, c_out_instr}, {2'b00, 32'h0, NOP});
    chk("fl1_c_rdy",    c_in_ready, 1);
    nxt();
    set_in(0, 32'h0, 0, 1, 0); look();
    chk("fl2_s_pc", {s_out_valid, s_out_pc}, {1'b1, 32'h500});
    chk("fl2_c_pc", {c_out_valid, c_out_pc}, {1'b1, 32'h500});
    nxt();

    // Fault passthrough.
    set_in(1, 32'h300, 1, 0, 0); look();
    chk("flt0_s_fault", s_out_fault, 0);
    nxt();
    set_in(0, 32'h0, 0, 0, 0); look();
    chk("flt1_s", {s_out_fault, s_out_pc}, {1'b1, 32'h300});
    chk("flt1_c", {c_out_fault, c_out_pc}, {1'b1, 32'h300});
    nxt();
    set_in(0, 32'h0, 0, 1, 0); look();
    chk("flt2_s_fault", s_out_fault, 1);
    nxt();
    look();
    chk("flt3_s_fault", {s_out_valid, s_out_fault}, 2'b00);
    chk("flt3_c_fault", {c_out_valid, c_out_fault}, 2'b00);
    nxt();

    // Reset mid-transfer: held entry vanishes.
    set_in(1, 32'h600, 0, 0, 0); nxt();
    set_in(0, 32'h0, 0, 0, 0);
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    look();
    chk("rstm_s", {s_out_valid, s_out_pc, s_out_instr, s_in_ready}, {1'b0, 32'h0, NOP, 1'b1});
    chk("rstm_c", {c_out_valid, c_out_pc, c_out_instr, c_in_ready}, {1'b0, 32'h0, NOP, 1'b1});
    nxt();

    // Random traffic checked by the monitor.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      in_fault  = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      rst_n     = ($urandom_range(0, 999) != 0);
      nxt();
    end

    // Drain.
    rst_n = 1'b1;
    set_in(0, 32'h0, 0, 1, 0);
    repeat (4) nxt();
    look();
    chk("end_s_q_empty", exp_q_s.size(), 0);
    chk("end_c_q_empty", exp_q_c.size(), 0);
    chk("end_s_valid",   s_out_valid, 0);
    chk("end_c_valid",   c_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
# if_id_skid

Parametrised IF/ID pipeline boundary that carries a fetched instruction, its PC and a fetch-fault flag from fetch to decode. It uses a valid/ready handshake instead of an unconditional per-cycle register. An optional two-entry skid buffer keeps `in_ready` registered while sustaining one transfer per cycle. A synchronous flush discards everything in flight and presents a NOP bubble to decode.

## Interface
- `XLEN`, 32: PC width.
- `ILEN`, 32: instruction width.
- `NOP`, 32'h0000_0013: bubble instruction (`addi x0,x0,0`); width `ILEN`.
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational ready.

- `clk` in 1: the block's only clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `flush` in 1: discard all held entries; sampled at the rising edge.
- `in_valid` in 1: fetch offers an entry.
- `in_ready` out 1: the block can accept an entry.
- `in_instr` in ILEN: fetched instruction.
- `in_pc` in XLEN: PC of `in_instr`.
- `in_fault` in 1: fetch access fault for this entry.
- `out_valid` out 1: decode entry is valid.
- `out_ready` in 1: decode consumes the entry.
- `out_instr` out ILEN: instruction to decode; equals `NOP` when `out_valid`=0.
- `out_pc` out XLEN: PC to decode; 0 when `out_valid`=0.
- `out_fault` out 1: fault flag; 0 when `out_valid`=0.

## Operation
- Accept: `in_valid & in_ready` at an edge.
- Deliver: `out_valid & out_ready` at an edge.
- Entries leave in strict arrival order. No entry is duplicated or dropped except by `flush` or reset.

**SKID=1**
- Occupancy states:
  - EMPTY: no entries held.
  - ONE: main slot holds an entry.
  - FULL: main and skid slots both hold entries.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept without deliver -> FULL; the new entry goes to the skid slot.
  - ONE + accept + deliver -> ONE; the main slot is overwritten.
  - ONE + deliver only -> EMPTY.
  - FULL + deliver -> ONE; the skid slot moves to main.
  - FULL never accepts.
- Outputs:
  - `in_ready` = (state != FULL), driven from a flop.
  - `out_*` driven directly from the main slot.

**SKID=0**
- Single slot with EMPTY/ONE states.
- `in_ready` = `!out_valid | out_ready`, combinational.
- Accept and deliver in the same cycle reloads the slot.

**Common**
- `flush`, at the edge where it is sampled:
  - Forces the state to EMPTY.
  - Ignores any simultaneous accept; the input is dropped and fetch must not treat it as taken.
  - Ignores any simultaneous deliver; decode must gate on its own flush.
- `flush` and `rst_n` low produce identical state and outputs. `rst_n` low has priority over `flush`.
- Bubble outputs: whenever `out_valid`=0, `out_instr`=`NOP`, `out_pc`=0 and `out_fault`=0, in every state and not only after reset.
- Payload is opaque and carried unmodified; there is no arithmetic on PC or instruction.
- `in_*` values are don't-care when `in_valid`=0. Nothing is captured in that case.

## Timing
- Reset values, one edge after `rst_n` low:
  - `out_valid`=0, `out_instr`=`NOP`, `out_pc`=0, `out_fault`=0.
  - `in_ready`=1 (SKID=1), or 1 via combinational `!out_valid` (SKID=0).
- Latency: an entry accepted at edge N is on `out_*` with `out_valid`=1 after edge N. It holds stable until the edge where it is delivered.
- Throughput: with `out_ready` held high, one entry per cycle in both modes, with no bubbles.
- SKID=1 back-pressure:
  - `out_ready` dropping while ONE with `in_valid` high -> FULL after one edge; `in_ready`=0 from then.
  - `out_ready` returning -> ONE; `in_ready`=1 after that edge.
- Flush recovery: the first accept is possible at the edge immediately following the flush edge.
- Reset mid-transfer: held entries are lost without notification.

## Structure
- Shared core package holds:
  - `NOP` instruction constant.
  - `XLEN`/`ILEN` defaults.
  - Occupancy-state enum (EMPTY/ONE/FULL), so the id_ex and ex_mem successors reuse it.
- Submodule `pipe_slot`: one payload register with a load enable and a synchronous clear to the bubble value. It is instantiated once for main and, when SKID=1, once for skid.
- Control FSM and mode selection live in `if_id_skid`, using `generate` on `SKID`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `out_instr`=0x00000013, `out_pc`=0, `in_ready`=1.
- Streaming: with `out_ready`=1, PCs 0x100, 0x104, 0x108 accepted on consecutive cycles → the same PCs on `out_pc` on the following consecutive cycles, no gaps, in both modes.
- Back-pressure (SKID=1): accept 0x200 and 0x204, hold `out_ready`=0 → FULL, `in_ready`=0, `out_pc` stays 0x200. Raise `out_ready` → 0x200 then 0x204 delivered, and 0x208 offered meanwhile is accepted only after `in_ready` returns to 1.
- Flush priority: in FULL, assert `flush` with `in_valid`=1 and `out_ready`=1 → next cycle `out_valid`=0, NOP bubble on the outputs, `in_ready`=1; neither held entry nor the input appears later.
- Fault passthrough: entry at PC 0x300 with `in_fault`=1 → `out_fault`=1 only while that entry is valid on the outputs, 0 otherwise.
- Random valid/ready/flush for 10k cycles against a scoreboard → order preserved, no duplicates, and every bubble cycle shows `out_instr`=NOP.
